// File: rtl/even_odd_pkg.sv
// Shared constants for the even/odd classification stream.
// Mode encodings and parameter defaults used by the top and the counter sub-module.
package even_odd_pkg;

    localparam logic MODE_LSB    = 1'b0;
    localparam logic MODE_PARITY = 1'b1;

    localparam int WIDTH_DEFAULT = 4;
    localparam int CNT_W_DEFAULT = 8;

endpackage : even_odd_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear and increment in the same cycle restart the count at 1.
module sat_counter
    import even_odd_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? CNT_ONE : '0;
        end else if (inc) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule : sat_counter

// File: rtl/even_odd_stream.sv
// Classifies each accepted word as even or odd (by LSB or by word parity) into a
// one-entry output register with valid/ready handshake, and keeps per-class counts.
module even_odd_stream
    import even_odd_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_even,
    output logic             out_odd,
    output logic [CNT_W-1:0] even_cnt,
    output logic [CNT_W-1:0] odd_cnt
);

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] out_data_d,  out_data_q;
    logic             out_even_d,  out_even_q;
    logic             accept;
    logic             in_even;

    // Ready depends only on the output register state, never on in_valid.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        in_even = ~in_data[0];
        if (in_mode == MODE_PARITY) begin
            in_even = ~(^in_data);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_even_d  = out_even_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_even_d  = in_even;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_even_q  <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_even_q  <= out_even_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_even  = out_even_q;
    assign out_odd   = ~out_even_q;

    // Counters track acceptance, independent of the output handshake.
    sat_counter #(.CNT_W(CNT_W)) u_even_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (accept && in_even),
        .q     (even_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_odd_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (accept && !in_even),
        .q     (odd_cnt)
    );

endmodule : even_odd_stream

// File: tb/tb_even_odd_stream.sv
// Bench for even_odd_stream: a wide-counter and a 2-bit-counter instance share stimulus
// and are compared each cycle against a behavioural model of the stream.
module tb_even_odd_stream;

    localparam int W   = 4;
    localparam int CW  = 8;
    localparam int CW2 = 2;
    localparam int MAX_A = (1 << CW) - 1;
    localparam int MAX_B = (1 << CW2) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_mode = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_data = '0;

    logic          in_ready_a, out_valid_a, out_even_a, out_odd_a;
    logic [W-1:0]  out_data_a;
    logic [CW-1:0] even_cnt_a, odd_cnt_a;
    logic          in_ready_b, out_valid_b, out_even_b, out_odd_b;
    logic [W-1:0]  out_data_b;
    logic [CW2-1:0] even_cnt_b, odd_cnt_b;

    even_odd_stream #(.WIDTH(W), .CNT_W(CW)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_even(out_even_a), .out_odd(out_odd_a),
        .even_cnt(even_cnt_a), .odd_cnt(odd_cnt_a)
    );

    even_odd_stream #(.WIDTH(W), .CNT_W(CW2)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_even(out_even_b), .out_odd(out_odd_b),
        .even_cnt(even_cnt_b), .odd_cnt(odd_cnt_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    bit           m_valid;
    logic [W-1:0] m_data;
    bit           m_even;
    int           m_ea, m_oa, m_eb, m_ob;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_even(input logic [W-1:0] d, input bit mode);
        if (mode) return ($countones(d) % 2) == 0;
        return (int'(d) % 2) == 0;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v < mx) ? v + 1 : mx;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_vld_a"}, 64'(out_valid_a), 64'(m_valid));
        chk({tag, "_vld_b"}, 64'(out_valid_b), 64'(m_valid));
        if (m_valid) begin
            chk({tag, "_data"}, 64'(out_data_a), 64'(m_data));
            chk({tag, "_even"}, 64'(out_even_a), 64'(m_even));
            chk({tag, "_odd"},  64'(out_odd_a),  64'(!m_even));
            chk({tag, "_even_b"}, 64'(out_even_b), 64'(m_even));
        end
        chk({tag, "_ecnt_a"}, 64'(even_cnt_a), 64'(m_ea));
        chk({tag, "_ocnt_a"}, 64'(odd_cnt_a),  64'(m_oa));
        chk({tag, "_ecnt_b"}, 64'(even_cnt_b), 64'(m_eb));
        chk({tag, "_ocnt_b"}, 64'(odd_cnt_b),  64'(m_ob));
    endtask

    task automatic cycle(input bit v, input logic [W-1:0] d, input bit mode,
                         input bit rdy, input bit c, input string tag);
        bit exp_rdy, acc, ev;
        in_valid  = v;
        in_data   = d;
        in_mode   = mode;
        out_ready = rdy;
        clr       = c;
        #1;
        exp_rdy = !m_valid || rdy;
        chk({tag, "_in_ready"},   64'(in_ready_a), 64'(exp_rdy));
        chk({tag, "_in_ready_b"}, 64'(in_ready_b), 64'(exp_rdy));
        acc = v && exp_rdy;
        ev  = ref_even(d, mode);
        @(posedge clk);
        if (acc) begin
            m_valid = 1'b1;
            m_data  = d;
            m_even  = ev;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        if (c) begin
            m_ea = (acc && ev) ? 1 : 0;
            m_oa = (acc && !ev) ? 1 : 0;
            m_eb = m_ea;
            m_ob = m_oa;
        end else if (acc) begin
            if (ev) begin
                m_ea = sat(m_ea, MAX_A);
                m_eb = sat(m_eb, MAX_B);
            end else begin
                m_oa = sat(m_oa, MAX_A);
                m_ob = sat(m_ob, MAX_B);
            end
        end
        #1;
        check_outputs(tag);
    endtask

    // Asserts reset away from the clock edge and checks the forced values before any edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        m_valid = 1'b0;
        m_data  = '0;
        m_even  = 1'b1;
        m_ea = 0; m_oa = 0; m_eb = 0; m_ob = 0;
        chk({tag, "_rst_data"}, 64'(out_data_a), 64'(0));
        chk({tag, "_rst_even"}, 64'(out_even_a), 64'(1));
        chk({tag, "_rst_odd"},  64'(out_odd_a),  64'(0));
        chk({tag, "_rst_rdy"},  64'(in_ready_a), 64'(1));
        check_outputs({tag, "_rst"});
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [W-1:0] rd;
        logic [W-1:0] seq37 [3];
        seq37[0] = 4'b0011;
        seq37[1] = 4'b0111;
        seq37[2] = 4'b0000;

        @(posedge clk);
        #2;
        do_reset("init");

        // LSB mode stream 0..10 at full rate.
        for (int a = 0; a <= 10; a++) cycle(1'b1, W'(a), 1'b0, 1'b1, 1'b0, "lsb");
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, "lsb_drain");
        chk("lsb_final_even", 64'(even_cnt_a), 64'(6));
        chk("lsb_final_odd",  64'(odd_cnt_a),  64'(5));

        // Word-parity mode.
        for (int i = 0; i < 3; i++) cycle(1'b1, seq37[i], 1'b1, 1'b1, 1'b0, "parity");

        // Back-pressure hold with changing inputs, then release with a same-cycle accept.
        cycle(1'b1, 4'd5, 1'b0, 1'b1, 1'b0, "hold_acc");
        for (int i = 0; i < 3; i++) cycle(1'b1, W'(i + 8), 1'b1, 1'b0, 1'b0, "hold");
        cycle(1'b1, 4'd9, 1'b0, 1'b1, 1'b0, "release");
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, "release_drain");

        // Saturation of the 2-bit counters.
        do_reset("sat");
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'd2, 1'b0, 1'b1, 1'b0, "sat");

        // Clear together with an odd accept, then clear alone.
        do_reset("clr");
        for (int i = 0; i < 4; i++) cycle(1'b1, W'(i), 1'b0, 1'b1, 1'b0, "clr_pre");
        cycle(1'b1, 4'd5, 1'b0, 1'b1, 1'b1, "clr_acc");
        cycle(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, "clr_fill");
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, "clr_only");

        // Reset while a result is held.
        cycle(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, "midrst_pre");
        do_reset("midrst");
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, "post_rst");

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            rd = W'($urandom_range(15, 0));
            cycle(($urandom_range(3, 0) != 0), rd, 1'($urandom_range(1, 0)),
                  ($urandom_range(3, 0) != 0), ($urandom_range(15, 0) == 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_even_odd_stream
